agex_muldiv_ctrl: RTL and testbench

- Multi-cycle M-extension controller alongside the AGEX stage; sequences one in-flight MUL/MULH*/DIV*/REM* operation.
- Accepts an op from AGEX and produces the stall that holds DE/FE while busy.
- Returns a one-cycle result pulse with the destination register to the AGEX latch path.
- Supports kill on branch-redirect flush.

---
 rtl/muldiv_pkg.sv | 52 +++++
 rtl/muldiv_div_iter.sv | 68 ++++++
 rtl/agex_muldiv_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_agex_muldiv_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and decode helpers for the AGEX M-extension controller
//
// Purpose : funct3 op encodings, controller state encoding, op-class decode
//           helpers and the signed-division overflow constant.
// Ports   : none (package).
package muldiv_pkg;

   localparam int MULDIV_DBITS = 32;

   // RISC-V funct3 encodings of the M extension
   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   // Most negative dividend; divided by -1 it is the one signed-overflow case
   localparam logic [MULDIV_DBITS-1:0] DIV_OVF = {1'b1, {(MULDIV_DBITS-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_e;

   function automatic logic is_div_class(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_rem_op(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

   // DIV and REM are signed, DIVU and REMU are not
   function automatic logic is_div_signed(input logic [2:0] op);
      return op[2] & ~op[0];
   endfunction

   // rs1 is signed for MULH and MULHSU; the low half of MUL is sign-agnostic
   function automatic logic mul_src1_signed(input logic [2:0] op);
      return (op == OP_MULH) | (op == OP_MULHSU);
   endfunction

   function automatic logic mul_src2_signed(input logic [2:0] op);
      return op == OP_MULH;
   endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// rtl/muldiv_div_iter.sv - restoring divider datapath, one quotient bit per step
//
// Purpose : holds the partial remainder, the quotient shift register (which
//           initially carries the dividend) and the divisor; all unsigned.
// Ports   : clk_i, reset_i   clock, synchronous active-high reset
//           load_i           capture dividend_i/divisor_i, clear remainder
//           step_i           perform one shift/trial-subtract iteration
//           dividend_i       dividend magnitude
//           divisor_i        divisor magnitude
//           quo_o, rem_o     quotient / remainder magnitudes
module muldiv_div_iter #(
   parameter int DBITS = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [DBITS-1:0] dividend_i,
   input  logic [DBITS-1:0] divisor_i,
   output logic [DBITS-1:0] quo_o,
   output logic [DBITS-1:0] rem_o
);

   logic [DBITS-1:0] quo_q, quo_d;
   logic [DBITS-1:0] rem_q, rem_d;
   logic [DBITS-1:0] dvs_q, dvs_d;
   logic [DBITS:0]   rem_sh;
   logic [DBITS:0]   diff;

   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      // Shift the next dividend bit (quotient MSB) into the remainder
      rem_sh = {rem_q, quo_q[DBITS-1]};
      // One extra bit so the borrow shows up in the MSB
      diff   = rem_sh - {1'b0, dvs_q};
      if (load_i) begin
         quo_d = dividend_i;
         rem_d = '0;
         dvs_d = divisor_i;
      end else if (step_i) begin
         if (!diff[DBITS]) begin
            rem_d = diff[DBITS-1:0];
            quo_d = {quo_q[DBITS-2:0], 1'b1};
         end else begin
            rem_d = rem_sh[DBITS-1:0];
            quo_d = {quo_q[DBITS-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
      end
   end

   assign quo_o = quo_q;
   assign rem_o = rem_q;

endmodule

// File: rtl/agex_muldiv_ctrl.sv
// rtl/agex_muldiv_ctrl.sv - multi-cycle MUL/DIV/REM controller beside the AGEX stage
//
// Purpose : sequences one in-flight M-extension op, stalls DE/FE while busy,
//           returns a one-cycle done pulse with result and destination tag,
//           and abandons the op on a branch-redirect flush.
// Macro   : MULDIV_EARLY_OUT_EN - DIV-class ops with a zero divisor or
//           |src1| < |src2| skip the iterative divide and finish at T0+1.
// Ports   : clk, reset       clock, synchronous active-high reset
//           start, op        AGEX presents an M-op (funct3 in op)
//           src1, src2       rs1 / rs2 values, latched on accept
//           rd_in            destination tag, latched on accept
//           flush            branch redirect; kills the op, beats start
//           busy, stall      op in flight / DE-FE stall
//           done             one-cycle result-valid pulse
//           result, rd_out   result and tag; hold last value when done is 0
module agex_muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int DBITS      = 32,
   parameter int MUL_CYCLES = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [DBITS-1:0] src1,
   input  logic [DBITS-1:0] src2,
   input  logic [4:0]       rd_in,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [DBITS-1:0] result,
   output logic [4:0]       rd_out
);

   localparam int            CW       = $clog2(DBITS) + 1;
   // MUL state lasts MUL_CYCLES-1 cycles: counter runs from MUL_CYCLES-2 down to 0
   localparam logic [CW-1:0] MUL_LOAD = CW'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DBITS - 1);

   muldiv_state_e    state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             early_q, early_d;
   logic [2:0]       op_q;
   logic [DBITS-1:0] a_q, b_q;
   logic [4:0]       rd_q;
   logic [DBITS-1:0] result_q;
   logic [4:0]       rd_out_q;

   logic             accept;
   logic             early_hit;
   logic             div_step;
   logic [DBITS-1:0] mag1, mag2;
   logic [DBITS-1:0] quo_mag, rem_mag;

   logic [2*DBITS-1:0] mul_a, mul_b, prod;
   logic [DBITS-1:0]   mul_res;
   logic [DBITS-1:0]   quo, rem, div_res, res_now;
   logic               neg_q, neg_r;

   assign accept = (state_q == ST_IDLE) & start & ~flush;

   // Operand magnitudes for the unsigned divider; the most negative value
   // negates to itself, which is its correct unsigned magnitude.
   always_comb begin
      mag1 = src1;
      mag2 = src2;
      if (is_div_signed(op) && src1[DBITS-1]) mag1 = -src1;
      if (is_div_signed(op) && src2[DBITS-1]) mag2 = -src2;
   end

`ifdef MULDIV_EARLY_OUT_EN
   assign early_hit = (src2 == '0) | (mag1 < mag2);
`else
   assign early_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      early_d  = early_q;
      div_step = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               early_d = 1'b0;
               if (is_div_class(op)) begin
                  if (early_hit) begin
                     state_d = ST_DONE;
                     early_d = 1'b1;
                  end else begin
                     state_d = ST_DIV;
                     cnt_d   = DIV_LOAD;
                  end
               end else if (MUL_CYCLES > 1) begin
                  state_d = ST_MUL;
                  cnt_d   = MUL_LOAD;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DIV: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               div_step = 1'b1;
               if (cnt_q == '0) state_d = ST_DONE;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   muldiv_div_iter #(.DBITS(DBITS)) u_div_iter (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (accept),
      .step_i     (div_step),
      .dividend_i (mag1),
      .divisor_i  (mag2),
      .quo_o      (quo_mag),
      .rem_o      (rem_mag)
   );

   // The product is formed from latched operands; MUL_CYCLES is the
   // multicycle budget the multiplier is given before DONE samples it.
   always_comb begin
      mul_a   = {{DBITS{mul_src1_signed(op_q) & a_q[DBITS-1]}}, a_q};
      mul_b   = {{DBITS{mul_src2_signed(op_q) & b_q[DBITS-1]}}, b_q};
      prod    = mul_a * mul_b;
      mul_res = (op_q == OP_MUL) ? prod[DBITS-1:0] : prod[2*DBITS-1:DBITS];
   end

   // Sign fixup; divide-by-zero and early-out bypass the magnitude result.
   always_comb begin
      neg_q = is_div_signed(op_q) & (a_q[DBITS-1] ^ b_q[DBITS-1]);
      neg_r = is_div_signed(op_q) & a_q[DBITS-1];
      if (b_q == '0) begin
         quo = '1;
         rem = a_q;
      end else if (early_q) begin
         quo = '0;
         rem = a_q;
      end else begin
         quo = neg_q ? -quo_mag : quo_mag;
         rem = neg_r ? -rem_mag : rem_mag;
      end
      div_res = is_rem_op(op_q) ? rem : quo;
      res_now = is_div_class(op_q) ? div_res : mul_res;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         early_q  <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rd_q     <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         early_q <= early_d;
         if (accept) begin
            op_q <= op;
            a_q  <= src1;
            b_q  <= src2;
            rd_q <= rd_in;
         end
         if (done) begin
            result_q <= res_now;
            rd_out_q <= rd_q;
         end
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign stall  = busy | (start & ~flush);
   assign done   = (state_q == ST_DONE) & ~flush;
   assign result = done ? res_now : result_q;
   assign rd_out = done ? rd_q : rd_out_q;

endmodule

// File: tb/tb_agex_muldiv_ctrl.sv
// tb/tb_agex_muldiv_ctrl.sv - scoreboard bench for agex_muldiv_ctrl
module tb_agex_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int DBITS      = 32;
   localparam int MUL_CYCLES = 3;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int LAT_EARLY = 1;
`else
   localparam int LAT_EARLY = DBITS + 1;
`endif
   localparam int LAT_MUL = MUL_CYCLES;
   localparam int LAT_DIV = DBITS + 1;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  op;
   logic [31:0] src1, src2;
   logic [4:0]  rd_in;
   logic        busy, stall, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   agex_muldiv_ctrl #(.DBITS(DBITS), .MUL_CYCLES(MUL_CYCLES)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .src1   (src1),
      .src2   (src2),
      .rd_in  (rd_in),
      .flush  (flush),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .result (result),
      .rd_out (rd_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual rd=%0d result=%h required no done", rd_out, result);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_result"}, result, mon_e.res);
            chk({mon_e.name, "_rd"}, 32'(rd_out), 32'(mon_e.rd));
            chk({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   // Called at posedge+1; start is held for exactly one cycle and the operands
   // are scrambled afterwards so operand latching is exercised.
   task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp_res, input int lat, input bit push);
      exp_t e;
      start = 1'b1; op = o; src1 = a; src2 = b; rd_in = r;
      if (push) begin
         e.name = nm; e.res = exp_res; e.rd = r; e.cyc = cyc + lat;
         sb.push_back(e);
      end
      #1;
      chk({nm, "_stall_on_start"}, 32'(stall), 32'd1);
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0; src1 = 32'hDEADBEEF; src2 = 32'h12345678; rd_in = 5'd31;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout actual pending=%0d required 0", nm, sb.size());
         sb.delete();
      end
   endtask

   task automatic run(input string nm, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] r,
                      input logic [31:0] exp_res, input int lat);
      issue(nm, o, a, b, r, exp_res, lat, 1'b1);
      drain(nm);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0;
      src1 = '0; src2 = '0; rd_in = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_busy",   32'(busy),   32'd0);
      chk("rst_done",   32'(done),   32'd0);
      chk("rst_stall",  32'(stall),  32'd0);
      chk("rst_result", result,      32'd0);
      chk("rst_rd",     32'(rd_out), 32'd0);

      // MUL 7 * -3 with stall/busy checks
      issue("mul_7x-3", OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, LAT_MUL, 1'b1);
      chk("mul_busy_t1",  32'(busy),  32'd1);
      chk("mul_stall_t1", 32'(stall), 32'd1);
      drain("mul_7x-3");
      chk("mul_busy_after",  32'(busy),  32'd0);
      chk("mul_stall_after", 32'(stall), 32'd0);
      chk("mul_hold_result", result, 32'hFFFFFFEB);

      // Back-to-back directed vectors
      run("mulhu_max",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, LAT_MUL);
      run("mulh_min_x2", OP_MULH,   32'h80000000, 32'd2,        5'd2,  32'hFFFFFFFF, LAT_MUL);
      run("mulhsu_2xm1", OP_MULHSU, 32'd2,        32'hFFFFFFFF, 5'd3,  32'h00000001, LAT_MUL);
      run("div_m7_2",    OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, LAT_DIV);
      run("rem_m7_2",    OP_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, LAT_DIV);
      run("div_7_m2",    OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd8,  32'hFFFFFFFD, LAT_DIV);
      run("rem_7_m2",    OP_REM,    32'd7,        32'hFFFFFFFE, 5'd10, 32'h00000001, LAT_DIV);
      run("divu_100_7",  OP_DIVU,   32'd100,      32'd7,        5'd11, 32'd14,       LAT_DIV);
      run("remu_100_7",  OP_REMU,   32'd100,      32'd7,        5'd13, 32'd2,        LAT_DIV);
      run("divu_10_0",   OP_DIVU,   32'd10,       32'd0,        5'd14, 32'hFFFFFFFF, LAT_EARLY);
      run("remu_10_0",   OP_REMU,   32'd10,       32'd0,        5'd15, 32'd10,       LAT_EARLY);
      run("div_m7_0",    OP_DIV,    32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFFF, LAT_EARLY);
      run("div_ovf",     OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, LAT_DIV);
      run("rem_ovf",     OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000, LAT_DIV);
      run("div_3_7",     OP_DIV,    32'd3,        32'd7,        5'd19, 32'd0,        LAT_EARLY);
      run("rem_m3_7",    OP_REM,    32'hFFFFFFFD, 32'd7,        5'd20, 32'hFFFFFFFD, LAT_EARLY);

      // Flush at T0+10 kills the DIV; a MUL issued at T0+11 completes at T0+14
      t0 = cyc;
      issue("div_flushed", OP_DIVU, 32'd100, 32'd7, 5'd21, 32'd0, LAT_DIV, 1'b0);
      idle(9);
      chk("flush_cycle_pos", 32'(cyc), 32'(t0 + 10));
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy",  32'(busy),  32'd0);
      chk("flush_stall", 32'(stall), 32'd0);
      run("mul_after_flush", OP_MUL, 32'd2, 32'd3, 5'd22, 32'd6, LAT_MUL);

      // A different start during a busy DIV is ignored
      issue("divu_busy", OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, LAT_DIV, 1'b1);
      start = 1'b1; op = OP_MUL; src1 = 32'd5; src2 = 32'd5; rd_in = 5'd3;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("busy_ignore_busy",  32'(busy),  32'd1);
         chk("busy_ignore_stall", 32'(stall), 32'd1);
      end
      start = 1'b0;
      drain("divu_busy");
      idle(5);

      // start and flush together: no accept
      start = 1'b1; flush = 1'b1; op = OP_MUL; src1 = 32'd2; src2 = 32'd3; rd_in = 5'd6;
      #1;
      chk("sf_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("sf_busy", 32'(busy), 32'd0);
      idle(5);

      // Reset mid-DIV: outputs clear, no done afterwards
      issue("div_reset", OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd12, 32'd0, LAT_DIV, 1'b0);
      idle(5);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_rst_busy",   32'(busy),   32'd0);
      chk("mid_rst_done",   32'(done),   32'd0);
      chk("mid_rst_stall",  32'(stall),  32'd0);
      chk("mid_rst_result", result,      32'd0);
      chk("mid_rst_rd",     32'(rd_out), 32'd0);
      idle(40);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
